// File: rtl/branch_resolution_unit_r0.sv
// EX-stage branch resolution: owns the 2-bit BHT, resolves branches, issues a one-cycle redirect/flush.
// Optional statistics counters are built only when BRU_STATS_EN is defined.
module branch_resolution_unit_r0 #(
    parameter int BIT_WIDTH   = 32,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] if_pc,
    output logic                 if_pred_taken,
    input  logic                 ex_valid,
    input  logic [BIT_WIDTH-1:0] ex_pc,
    input  logic                 ex_pred_taken,
    input  logic                 ex_taken,
    input  logic [BIT_WIDTH-1:0] ex_target,
    output logic                 redirect_valid,
    output logic [BIT_WIDTH-1:0] redirect_pc,
    output logic                 flush,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispredicts
);

    localparam int BHT_DEPTH = 1 << INDEX_WIDTH;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [1:0]             bht [BHT_DEPTH];
    logic [INDEX_WIDTH-1:0] if_idx;
    logic [INDEX_WIDTH-1:0] ex_idx;
    logic                   accepted;
    logic                   mispredict;
    logic                   unused_if_pc_bits;

    assign if_idx            = if_pc[INDEX_WIDTH+1:2];
    assign ex_idx            = ex_pc[INDEX_WIDTH+1:2];
    assign unused_if_pc_bits = ^{if_pc[BIT_WIDTH-1:INDEX_WIDTH+2], if_pc[1:0]};

    // Reads the registered table, so a same-cycle update shows up only next cycle.
    assign if_pred_taken = bht[if_idx][1];

    // While in REDIRECT the EX slot holds a wrong-path instruction and is ignored.
    assign accepted   = ex_valid && (state == RUN);
    assign mispredict = accepted && (ex_pred_taken != ex_taken);

    function automatic logic [1:0] train(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'd3) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'd0) ? ctr : ctr - 2'd1;
    endfunction

    always_comb begin
        // NOTE: default assigned first so no path through the block infers a latch.
        state_next = state;
        case (state)
            RUN:      if (mispredict) state_next = REDIRECT;
            REDIRECT: state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_next;
            redirect_valid <= mispredict;
            if (mispredict) begin
                redirect_pc <= ex_taken ? ex_target : ex_pc + BIT_WIDTH'(4);
            end
        end
    end

    assign flush = redirect_valid;

    // NOTE: the BHT is reset explicitly because predictions must start weak-not-taken;
    // this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'd1;
            end
        end else if (accepted) begin
            bht[ex_idx] <= train(bht[ex_idx], ex_taken);
        end
    end

`ifdef BRU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (accepted)   stat_branches    <= stat_branches + 32'd1;
            if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolution_unit_r0.sv
// Self-checking bench for branch_resolution_unit_r0: vector table with a scoreboard queue,
// plus directed reset-sweep and reset-during-redirect sequences.
module tb_branch_resolution_unit_r0;

    localparam int NUM_VECS = 21;

`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic        ex_valid;
        logic [31:0] ex_pc;
        logic        ex_pred;
        logic        ex_taken;
        logic [31:0] ex_target;
        logic [31:0] if_pc;
        logic        exp_pred;
        logic        exp_rv;
        logic [31:0] exp_rpc;
        int          exp_b;
        int          exp_m;
    } vec_t;

    typedef struct {
        int          idx;
        logic        rv;
        logic [31:0] rpc;
        int          b;
        int          m;
    } post_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int    n_vectors    = 0;
    int    n_miscompare = 0;
    vec_t  vecs [NUM_VECS];
    post_t sb [$];

    branch_resolution_unit_r0 #(.BIT_WIDTH(32), .INDEX_WIDTH(6)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_pred_taken    (ex_pred_taken),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] st(input int x);
        return STATS ? 32'(x) : 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic pred,
                            input logic taken, input logic [31:0] tgt);
        ex_valid      = v;
        ex_pc         = pc;
        ex_pred_taken = pred;
        ex_taken      = taken;
        ex_target     = tgt;
    endtask

    task automatic check_outputs(input string tag, input logic rv, input logic [31:0] rpc,
                                 input int b, input int m);
        check({tag, " redirect_valid"}, 32'(redirect_valid), 32'(rv));
        check({tag, " flush"}, 32'(flush), 32'(rv));
        check({tag, " redirect_pc"}, redirect_pc, rpc);
        check({tag, " stat_branches"}, stat_branches, st(b));
        check({tag, " stat_mispredicts"}, stat_mispredicts, st(m));
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic apply(input int idx, input vec_t v);
        post_t p;
        drive_ex(v.ex_valid, v.ex_pc, v.ex_pred, v.ex_taken, v.ex_target);
        if_pc = v.if_pc;
        #1;
        check($sformatf("v%0d if_pred_taken", idx), 32'(if_pred_taken), 32'(v.exp_pred));
        sb.push_back('{idx, v.exp_rv, v.exp_rpc, v.exp_b, v.exp_m});
        @(posedge clk);
        #1;
        p = sb.pop_front();
        check_outputs($sformatf("v%0d", p.idx), p.rv, p.rpc, p.b, p.m);
    endtask

    task automatic sweep_bht(input string tag);
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'(i * 4);
            #1;
            check($sformatf("%s entry %0d", tag, i), 32'(if_pred_taken), 32'd0);
        end
    endtask

    initial begin
        //          valid pc            pred tkn target        if_pc    pred rv  rpc           b   m
        vecs[0]  = '{1'b1, 32'h40,       1'b0, 1'b1, 32'h100,      32'h40, 1'b0, 1'b1, 32'h100, 1,  1};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h40, 1'b1, 1'b0, 32'h100, 1,  1};
        vecs[2]  = '{1'b1, 32'h40,       1'b1, 1'b1, 32'h100,      32'h40, 1'b1, 1'b0, 32'h100, 2,  1};
        vecs[3]  = '{1'b1, 32'h40,       1'b1, 1'b1, 32'h100,      32'h40, 1'b1, 1'b0, 32'h100, 3,  1};
        vecs[4]  = '{1'b1, 32'h40,       1'b1, 1'b1, 32'h100,      32'h40, 1'b1, 1'b0, 32'h100, 4,  1};
        vecs[5]  = '{1'b1, 32'h40,       1'b1, 1'b0, 32'h100,      32'h40, 1'b1, 1'b1, 32'h44,  5,  2};
        vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h40, 1'b1, 1'b0, 32'h44,  5,  2};
        vecs[7]  = '{1'b1, 32'h40,       1'b0, 1'b0, 32'h100,      32'h40, 1'b1, 1'b0, 32'h44,  6,  2};
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h40, 1'b0, 1'b0, 32'h44,  6,  2};
        vecs[9]  = '{1'b1, 32'hC0,       1'b1, 1'b0, 32'h300,      32'h80, 1'b0, 1'b1, 32'hC4,  7,  3};
        vecs[10] = '{1'b1, 32'h80,       1'b0, 1'b1, 32'h200,      32'h80, 1'b0, 1'b0, 32'hC4,  7,  3};
        vecs[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h80, 1'b0, 1'b0, 32'hC4,  7,  3};
        vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'hC0, 1'b0, 1'b0, 32'hC4,  7,  3};
        vecs[13] = '{1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h12345678, 32'hFC, 1'b0, 1'b1, 32'h0,   8,  4};
        vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'hFC, 1'b0, 1'b0, 32'h0,   8,  4};
        vecs[15] = '{1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 32'h0,   9,  4};
        vecs[16] = '{1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 32'h0,   10, 4};
        vecs[17] = '{1'b1, 32'h0,        1'b0, 1'b1, 32'h500,      32'h0,  1'b0, 1'b1, 32'h500, 11, 5};
        vecs[18] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 32'h500, 11, 5};
        vecs[19] = '{1'b1, 32'h0,        1'b0, 1'b1, 32'h500,      32'h0,  1'b0, 1'b1, 32'h500, 12, 6};
        vecs[20] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,  1'b1, 1'b0, 32'h500, 12, 6};

        // Reset with a live branch on EX: reset must win over the update.
        rst   = 1'b1;
        if_pc = 32'h0;
        drive_ex(1'b1, 32'h40, 1'b0, 1'b1, 32'h100);
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 32'h0, 0, 0);
        rst = 1'b0;
        drive_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        sweep_bht("reset sweep");

        @(posedge clk);
        #1;
        check_outputs("idle", 1'b0, 32'h0, 0, 0);

        for (int i = 0; i < NUM_VECS; i++) begin
            apply(i, vecs[i]);
        end

        // Mispredict on 0x40 (counter 1 -> 2), then reset lands in the REDIRECT cycle.
        drive_ex(1'b1, 32'h40, 1'b0, 1'b1, 32'h100);
        if_pc = 32'h40;
        @(posedge clk);
        #1;
        check_outputs("pre-rst redirect", 1'b1, 32'h100, 13, 7);
        check("pre-rst pred 0x40", 32'(if_pred_taken), 32'd1);

        rst = 1'b1;
        drive_ex(1'b1, 32'h20, 1'b0, 1'b1, 32'h600);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_outputs("rst in redirect", 1'b0, 32'h0, 0, 0);
        sweep_bht("post-rst sweep");

        // A counter reset to 1 must reach weak-taken after one taken resolution.
        @(posedge clk);
        #1;
        drive_ex(1'b1, 32'h20, 1'b0, 1'b1, 32'h600);
        @(posedge clk);
        #1;
        drive_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_outputs("post-rst branch", 1'b1, 32'h600, 1, 1);
        if_pc = 32'h20;
        #1;
        check("post-rst pred 0x20", 32'(if_pred_taken), 32'd1);
        @(posedge clk);
        #1;
        check_outputs("post-rst drop", 1'b0, 32'h600, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit_r0.md
# branch_resolution_unit_r0

Execute-stage counterpart to the ID-stage hazard/branch-prediction unit: it owns the 2-bit branch history table (BHT). It answers fetch-stage prediction lookups, resolves each conditional branch once its outcome is known in EX, and trains the table. On a misprediction it issues a registered one-cycle PC redirect and IF/ID + ID/EX flush, and squashes the wrong-path branch that follows.

## Interface
- BIT_WIDTH, 32, PC/target width
- INDEX_WIDTH, 6, BHT index bits (2^INDEX_WIDTH entries, indexed by pc[INDEX_WIDTH+1:2])
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_pc  in  BIT_WIDTH  fetch PC for lookup
- if_pred_taken  out  1  combinational prediction: MSB of the addressed counter
- ex_valid  in  1  EX holds a conditional branch this cycle
- ex_pc  in  BIT_WIDTH  PC of the EX branch
- ex_pred_taken  in  1  prediction carried down the pipeline with the branch
- ex_taken  in  1  resolved outcome
- ex_target  in  BIT_WIDTH  resolved taken target
- redirect_valid  out  1  registered: load PC with redirect_pc
- redirect_pc  out  BIT_WIDTH  registered corrected PC
- flush  out  1  registered: flush IF/ID and ID/EX (equals redirect_valid)
- stat_branches  out  32  resolved-branch count (see Configuration)
- stat_mispredicts  out  32  misprediction count (see Configuration)

## Operation
- BHT: 2^INDEX_WIDTH 2-bit saturating counters (0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T). Reset sets every entry to 1.
- Lookup: `if_pred_taken = bht[if_pc[INDEX_WIDTH+1:2]][1]`. Purely combinational, with no dependency on ex_* inputs.
- FSM states RUN and REDIRECT. Reset enters RUN.
- A resolution is accepted only when ex_valid=1 and state=RUN.
- On an accepted resolution, the counter at ex_pc[INDEX_WIDTH+1:2] is updated:
  - ex_taken=1: increment, saturating at 3.
  - ex_taken=0: decrement, saturating at 0.
- Mispredict = accepted && (ex_pred_taken != ex_taken). When it occurs:
  - Next state is REDIRECT.
  - redirect_pc register loads ex_target if ex_taken=1, else ex_pc+4 (mod 2^BIT_WIDTH, wraps).
- REDIRECT:
  - redirect_valid=flush=1 for exactly one cycle.
  - ex_valid is ignored, since EX holds a wrong-path instruction: no BHT update, no statistics, no mispredict.
  - Unconditionally returns to RUN.
- Correct prediction: BHT updates, no redirect, state stays RUN.
- Read/write to the same index in the same cycle: if_pred_taken returns the pre-update value.

## Timing
- Reset values: redirect_valid=0, flush=0, redirect_pc=0, stat_*=0, state=RUN, all counters=1.
- Lookup latency is 0 cycles (combinational).
- BHT update becomes visible on if_pred_taken in the cycle after the accepting edge.
- A mispredict sampled at edge N drives redirect_valid/flush high during cycle N..N+1, i.e. they drop at edge N+1. Consecutive redirects are therefore impossible; the minimum spacing is 2 cycles.
- rst asserted during REDIRECT: outputs are 0 in the following cycle and the pending redirect is discarded.
- rst has priority over every update in the same edge.

## Configuration
- Macro: BRU_STATS_EN.
- Defined:
  - stat_branches increments on each accepted resolution.
  - stat_mispredicts increments on each mispredict.
  - Both wrap at 2^32 and are reset to 0.
- Undefined: no counter flops are built; stat_branches and stat_mispredicts are tied to 0. All other behaviour is identical.

## Test plan
- Reset, then sweep if_pc=0x0..0xFC step 4 → if_pred_taken=0 for all 64 entries; redirect_valid=0.
- Branch at ex_pc=0x40, ex_pred_taken=0, ex_taken=1, ex_target=0x100 → next cycle redirect_valid=flush=1, redirect_pc=0x100, for one cycle only. Then if_pc=0x40 predicts 1 (counter 2).
- Same branch taken 3 more times with correct ex_pred_taken=1 → no redirect, counter saturates at 3. Then two not-taken resolutions → counter 1, if_pred_taken=0, and the first of them redirects to 0x44.
- Mispredict at edge N with ex_valid=1 again in cycle N+1 (ex_pc=0x80, mispredicted) → no second redirect, entry 0x80 unchanged, stat_mispredicts=1 (with BRU_STATS_EN).
- ex_pc=0xFFFFFFFC, predicted taken, actually not taken → redirect_pc=0x00000000.
- Assert rst in the REDIRECT cycle → the next cycle has redirect_valid=0, all counters=1, and stats=0.
